// File: rtl/uart_frame_receiver_if.sv
// Payload stream and frame status bundle between uart_frame_receiver and the capture buffer.
`timescale 1ns/1ps
interface uart_frame_receiver_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_first;
  logic       rx_last;
  logic [7:0] frame_len;
  logic       frame_done;
  logic       frame_err;

  modport master (
    output rx_data, rx_valid, rx_first, rx_last, frame_len, frame_done, frame_err
  );

  modport slave (
    input rx_data, rx_valid, rx_first, rx_last, frame_len, frame_done, frame_err
  );
endinterface

// File: rtl/uart_frame_receiver.sv
// 8N1 UART receiver (16x oversampling) feeding a [SYNC][LEN][payload] frame parser.
// Optional trailing checksum byte enabled by defining RX_CHECKSUM_EN.
`timescale 1ns/1ps
module uart_frame_receiver #(
  parameter int         CLK_FREQ  = 50_000_000,
  parameter int         BAUD      = 115_200,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic                   Clk,
  input  logic                   reset,
  input  logic                   UART_In,
  uart_frame_receiver_if.master  rx
);

  localparam int DIV   = CLK_FREQ / (16 * BAUD);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_BREAK
  } rx_state_t;

  typedef enum logic [1:0] {
    F_SYNC,
    F_LEN,
    F_PAY
`ifdef RX_CHECKSUM_EN
    , F_CSUM
`endif
  } fr_state_t;

  logic             sync1_q, sync2_q;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             tick;
  logic             line;

  rx_state_t        rx_state_q, rx_state_d;
  logic [3:0]       os_cnt_q, os_cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             byte_stb_q, byte_stb_d;
  logic             ferr_stb_q, ferr_stb_d;

  fr_state_t        fr_state_q, fr_state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             first_pend_q, first_pend_d;
`ifdef RX_CHECKSUM_EN
  logic [7:0]       acc_q, acc_d;
`endif

  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             rx_first_q, rx_first_d;
  logic             rx_last_q, rx_last_d;
  logic [7:0]       frame_len_q, frame_len_d;
  logic             frame_done_q, frame_done_d;
  logic             frame_err_q, frame_err_d;

  assign line = sync2_q;
  assign tick = (div_cnt_q == DIV_W'(DIV - 1));

  // Oversample divider; realigned to the falling edge of each start bit.
  always_comb begin
    div_cnt_d = div_cnt_q + 1'b1;
    if (((rx_state_q == RX_IDLE) && !line) || tick) begin
      div_cnt_d = '0;
    end
  end

  // State registers for both FSMs, the synchroniser and the output flops.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      div_cnt_q    <= '0;
      rx_state_q   <= RX_IDLE;
      os_cnt_q     <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      byte_stb_q   <= 1'b0;
      ferr_stb_q   <= 1'b0;
      fr_state_q   <= F_SYNC;
      cnt_q        <= '0;
      first_pend_q <= 1'b0;
`ifdef RX_CHECKSUM_EN
      acc_q        <= '0;
`endif
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      rx_first_q   <= 1'b0;
      rx_last_q    <= 1'b0;
      frame_len_q  <= '0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      sync1_q      <= UART_In;
      sync2_q      <= sync1_q;
      div_cnt_q    <= div_cnt_d;
      rx_state_q   <= rx_state_d;
      os_cnt_q     <= os_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      byte_stb_q   <= byte_stb_d;
      ferr_stb_q   <= ferr_stb_d;
      fr_state_q   <= fr_state_d;
      cnt_q        <= cnt_d;
      first_pend_q <= first_pend_d;
`ifdef RX_CHECKSUM_EN
      acc_q        <= acc_d;
`endif
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      rx_first_q   <= rx_first_d;
      rx_last_q    <= rx_last_d;
      frame_len_q  <= frame_len_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    case (rx_state_q)
      RX_IDLE:  if (!line) rx_state_d = RX_START;
      RX_START: if (tick && os_cnt_q == 4'd7) rx_state_d = line ? RX_IDLE : RX_DATA;
      RX_DATA:  if (tick && os_cnt_q == 4'd15 && bit_cnt_q == 3'd7) rx_state_d = RX_STOP;
      RX_STOP:  if (tick && os_cnt_q == 4'd15) rx_state_d = line ? RX_IDLE : RX_BREAK;
      RX_BREAK: if (line) rx_state_d = RX_IDLE;
      default:  rx_state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    os_cnt_d   = os_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    byte_stb_d = 1'b0;
    ferr_stb_d = 1'b0;
    case (rx_state_q)
      RX_START: begin
        if (tick) os_cnt_d = (os_cnt_q == 4'd7) ? 4'd0 : os_cnt_q + 4'd1;
      end
      RX_DATA: begin
        if (tick) begin
          os_cnt_d = os_cnt_q + 4'd1;
          if (os_cnt_q == 4'd15) begin
            shift_d   = {line, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      RX_STOP: begin
        if (tick) begin
          os_cnt_d = os_cnt_q + 4'd1;
          if (os_cnt_q == 4'd15) begin
            byte_stb_d = line;
            ferr_stb_d = !line;
          end
        end
      end
      default: begin
        os_cnt_d  = '0;
        bit_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    fr_state_d = fr_state_q;
    case (fr_state_q)
      F_SYNC: if (byte_stb_q && shift_q == SYNC_BYTE) fr_state_d = F_LEN;
      F_LEN: begin
        if (ferr_stb_q) fr_state_d = F_SYNC;
        else if (byte_stb_q) fr_state_d = (shift_q == 8'd0) ? F_SYNC : F_PAY;
      end
      F_PAY: begin
        if (ferr_stb_q) fr_state_d = F_SYNC;
`ifdef RX_CHECKSUM_EN
        else if (byte_stb_q && cnt_q == 8'd1) fr_state_d = F_CSUM;
`else
        else if (byte_stb_q && cnt_q == 8'd1) fr_state_d = F_SYNC;
`endif
      end
`ifdef RX_CHECKSUM_EN
      F_CSUM: if (ferr_stb_q || byte_stb_q) fr_state_d = F_SYNC;
`endif
      default: fr_state_d = F_SYNC;
    endcase
  end

  always_comb begin
    cnt_d        = cnt_q;
    first_pend_d = first_pend_q;
`ifdef RX_CHECKSUM_EN
    acc_d        = acc_q;
`endif
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    rx_first_d   = 1'b0;
    rx_last_d    = 1'b0;
    frame_len_d  = frame_len_q;
    frame_done_d = 1'b0;
    frame_err_d  = 1'b0;
    case (fr_state_q)
      F_LEN: begin
        if (ferr_stb_q) begin
          frame_err_d = 1'b1;
        end else if (byte_stb_q) begin
          if (shift_q == 8'd0) begin
            frame_err_d = 1'b1;
          end else begin
            frame_len_d  = shift_q;
            cnt_d        = shift_q;
            first_pend_d = 1'b1;
`ifdef RX_CHECKSUM_EN
            // Seeded with the marker so the check byte covers the whole frame.
            acc_d        = SYNC_BYTE ^ shift_q;
`endif
          end
        end
      end
      F_PAY: begin
        if (ferr_stb_q) begin
          frame_err_d = 1'b1;
        end else if (byte_stb_q) begin
          rx_data_d    = shift_q;
          rx_valid_d   = 1'b1;
          rx_first_d   = first_pend_q;
          rx_last_d    = (cnt_q == 8'd1);
          first_pend_d = 1'b0;
          cnt_d        = cnt_q - 8'd1;
`ifdef RX_CHECKSUM_EN
          acc_d        = acc_q ^ shift_q;
`else
          frame_done_d = (cnt_q == 8'd1);
`endif
        end
      end
`ifdef RX_CHECKSUM_EN
      F_CSUM: begin
        if (ferr_stb_q) begin
          frame_err_d = 1'b1;
        end else if (byte_stb_q) begin
          frame_done_d = (shift_q == acc_q);
          frame_err_d  = (shift_q != acc_q);
        end
      end
`endif
      default: ;
    endcase
  end

  assign rx.rx_data    = rx_data_q;
  assign rx.rx_valid   = rx_valid_q;
  assign rx.rx_first   = rx_first_q;
  assign rx.rx_last    = rx_last_q;
  assign rx.frame_len  = frame_len_q;
  assign rx.frame_done = frame_done_q;
  assign rx.frame_err  = frame_err_q;

endmodule
